seg_countdown_display: RTL

- Downstream consumer of the traffic-light counter's 5-bit remaining-time value `count` (0..31). Runs in the 100 MHz domain.
- Converts the value to two BCD digits with a sequential shift-and-add-3 (double-dabble) engine.
- Drives a multiplexed 8-position seven-segment display: units on position 0, tens on position 1, positions 2..7 blank.
- Updates the displayed value atomically, so a half-converted number is never shown.

---
 rtl/seg_countdown_display.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/seg_countdown_display.sv
// rtl/seg_countdown_display.sv - double-dabble BCD conversion of a 0..31 count onto a scanned 8-position seven-segment display.
// Optional LEAD_ZERO_BLANK_EN: blank the tens position when the tens digit is zero.
module seg_countdown_display #(
  parameter int SCAN_DIV    = 100000,
  parameter int SCAN_DIGITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] count,
  output logic [7:0] seg,
  output logic [7:0] sel,
  output logic       busy
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);
  localparam logic [2:0] PTR_LAST = 3'(SCAN_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t        state, state_nx;
  logic [4:0]    last_cnt, last_cnt_nx;
  logic [12:0]   sh, sh_nx;
  logic [2:0]    step, step_nx;
  logic [3:0]    tens_r, ones_r, tens_nx, ones_nx;
  logic          start;

  logic [3:0]    t_adj, o_adj;
  logic [12:0]   sh_shift;

  logic [PW-1:0] ps, ps_nx;
  logic [2:0]    ptr, ptr_nx;
  logic          scan_step;
  logic [7:0]    seg_nx, sel_nx;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  // One double-dabble step: add-3 correction on both BCD nibbles, then shift the whole register.
  assign t_adj    = (sh[12:9] >= 4'd5) ? sh[12:9] + 4'd3 : sh[12:9];
  assign o_adj    = (sh[8:5]  >= 4'd5) ? sh[8:5]  + 4'd3 : sh[8:5];
  assign sh_shift = {t_adj[2:0], o_adj, sh[4:0], 1'b0};

  assign busy = (state != IDLE);

  always_comb begin
    state_nx    = state;
    last_cnt_nx = last_cnt;
    sh_nx       = sh;
    step_nx     = step;
    tens_nx     = tens_r;
    ones_nx     = ones_r;
    start       = 1'b0;
    case (state)
      IDLE: start = (count != last_cnt);
      CONV: begin
        sh_nx   = sh_shift;
        step_nx = step + 3'd1;
        if (step == 3'd4) state_nx = LOAD;
      end
      LOAD: begin
        tens_nx  = sh[12:9];
        ones_nx  = sh[8:5];
        state_nx = IDLE;
        // Restart straight from LOAD so a late count change is never lost and busy stays high.
        start    = (count != last_cnt);
      end
      default: state_nx = IDLE;
    endcase
    if (start) begin
      last_cnt_nx = count;
      sh_nx       = {8'b0, count};
      step_nx     = 3'd0;
      state_nx    = CONV;
    end
  end

  always_comb begin
    ps_nx     = ps + 1'b1;
    ptr_nx    = ptr;
    scan_step = 1'b0;
    if (ps == PS_LAST) begin
      ps_nx     = '0;
      scan_step = 1'b1;
      ptr_nx    = (ptr == PTR_LAST) ? 3'd0 : ptr + 3'd1;
    end
    sel_nx = 8'h01 << ptr_nx;
    case (ptr_nx)
      3'd0:    seg_nx = seg7(ones_r);
`ifdef LEAD_ZERO_BLANK_EN
      3'd1:    seg_nx = (tens_r == 4'd0) ? 8'h00 : seg7(tens_r);
`else
      3'd1:    seg_nx = seg7(tens_r);
`endif
      default: seg_nx = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_cnt <= 5'd0;
      sh       <= 13'd0;
      step     <= 3'd0;
      tens_r   <= 4'd0;
      ones_r   <= 4'd0;
    end else begin
      state    <= state_nx;
      last_cnt <= last_cnt_nx;
      sh       <= sh_nx;
      step     <= step_nx;
      tens_r   <= tens_nx;
      ones_r   <= ones_nx;
    end
  end

  // sel and seg only move on a scan step, using the digit registers as they were before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps  <= '0;
      ptr <= 3'd0;
      sel <= 8'h01;
      seg <= 8'h3F;
    end else begin
      ps  <= ps_nx;
      ptr <= ptr_nx;
      if (scan_step) begin
        sel <= sel_nx;
        seg <= seg_nx;
      end
    end
  end

endmodule
